// File: rtl/sa_pkg.sv
// Shared types and constants for the 2x2 systolic array feeder.
package sa_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // Weights shift down the columns, so the row-2 beat is sent first.
  localparam logic BEAT_ROW2 = 1'b0;
  localparam logic BEAT_ROW1 = 1'b1;

endpackage

// File: rtl/sa_skew_line.sv
// N-stage register delay line with synchronous reset, used for the skew lanes.
module sa_skew_line #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [N-1:0][W-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = int'(N) - 1; i > 0; i--) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/sa22_feeder.sv
// Weight loader and skewed activation sequencer for the 2x2 systolic array.
// Optional top-edge bias injection is compiled in with SA_FEEDER_BIAS_EN.
module sa22_feeder
  import sa_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data0,
  input  logic [DATA_W-1:0] w_data1,
`ifdef SA_FEEDER_BIAS_EN
  input  logic [DATA_W-1:0] b_data0,
  input  logic [DATA_W-1:0] b_data1,
`endif
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_last,
  input  logic [DATA_W-1:0] a_data0,
  input  logic [DATA_W-1:0] a_data1,
  output logic [DATA_W-1:0] weight_in11,
  output logic [DATA_W-1:0] weight_in12,
  output logic              weight_en,
  output logic [DATA_W-1:0] activation_in11,
  output logic [DATA_W-1:0] activation_in21,
  output logic [DATA_W-1:0] partial_sum_in11,
  output logic [DATA_W-1:0] partial_sum_in12,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  state_e            state_q, state_d;
  logic              beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              busy_q, w_ready_q, a_ready_q;
  logic              we_q, we_d;
  logic [DATA_W-1:0] w0_q, w0_d, w1_q, w1_d;
  logic [DATA_W-1:0] lane_a_d, lane_b_d;
  logic              w_fire, a_fire;

  assign w_fire = w_valid && w_ready_q;
  assign a_fire = a_valid && a_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= BEAT_ROW2;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      we_q      <= 1'b0;
      w0_q      <= '0;
      w1_q      <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      busy_q    <= (state_d != IDLE);
      w_ready_q <= (state_d == IDLE) || (state_d == LOAD_W);
      a_ready_q <= (state_d == STREAM);
      we_q      <= we_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    we_d     = w_fire;
    w0_d     = w_fire ? w_data0 : w0_q;
    w1_d     = w_fire ? w_data1 : w1_q;
    lane_a_d = a_fire ? a_data0 : '0;
    lane_b_d = a_fire ? a_data1 : '0;

    case (state_q)
      IDLE: begin
        if (w_fire) begin
          state_d = LOAD_W;
          beat_d  = BEAT_ROW1;
        end
      end
      LOAD_W: begin
        if (w_fire) begin
          if (beat_q == BEAT_ROW1) begin
            state_d = STREAM;
            beat_d  = BEAT_ROW2;
          end else begin
            beat_d  = BEAT_ROW1;
          end
        end
      end
      STREAM: begin
        if (a_fire && a_last) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row 2 lags row 1 by one cycle to form the diagonal wavefront.
  sa_skew_line #(.W(DATA_W), .N(1)) u_lane_a (
    .clk (clk), .rst (rst), .d_i (lane_a_d), .q_o (activation_in11)
  );
  sa_skew_line #(.W(DATA_W), .N(2)) u_lane_b (
    .clk (clk), .rst (rst), .d_i (lane_b_d), .q_o (activation_in21)
  );

`ifdef SA_FEEDER_BIAS_EN
  logic [DATA_W-1:0] b0_q, b1_q, p11_q, p12_q;
  logic              va_q, vb_q;

  sa_skew_line #(.W(1), .N(1)) u_valid_a (
    .clk (clk), .rst (rst), .d_i (a_fire), .q_o (va_q)
  );
  sa_skew_line #(.W(1), .N(2)) u_valid_b (
    .clk (clk), .rst (rst), .d_i (a_fire), .q_o (vb_q)
  );

  // Bias rides one cycle behind each lane's valid activation.
  always_ff @(posedge clk) begin
    if (rst) begin
      b0_q  <= '0;
      b1_q  <= '0;
      p11_q <= '0;
      p12_q <= '0;
    end else begin
      if (w_fire && (beat_q == BEAT_ROW1)) begin
        b0_q <= b_data0;
        b1_q <= b_data1;
      end
      p11_q <= va_q ? b0_q : '0;
      p12_q <= vb_q ? b1_q : '0;
    end
  end

  assign partial_sum_in11 = p11_q;
  assign partial_sum_in12 = p12_q;
`else
  assign partial_sum_in11 = '0;
  assign partial_sum_in12 = '0;
`endif

  assign w_ready     = w_ready_q;
  assign a_ready     = a_ready_q;
  assign weight_en   = we_q;
  assign weight_in11 = w0_q;
  assign weight_in12 = w1_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sa22_feeder.sv
// Self-checking bench for sa22_feeder: timeline model plus directed literal checks.
module tb_sa22_feeder;

  localparam int DW        = 16;
  localparam int DRAIN_CYC = 4;
  localparam int N         = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_valid, a_valid, a_last;
  logic [DW-1:0] w_data0, w_data1, b_data0, b_data1, a_data0, a_data1;
  logic          w_ready, a_ready, weight_en, busy, done;
  logic [DW-1:0] weight_in11, weight_in12, activation_in11, activation_in21;
  logic [DW-1:0] partial_sum_in11, partial_sum_in12;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sa22_feeder #(.DATA_W(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data0(w_data0), .w_data1(w_data1),
`ifdef SA_FEEDER_BIAS_EN
    .b_data0(b_data0), .b_data1(b_data1),
`endif
    .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last),
    .a_data0(a_data0), .a_data1(a_data1),
    .weight_in11(weight_in11), .weight_in12(weight_in12), .weight_en(weight_en),
    .activation_in11(activation_in11), .activation_in21(activation_in21),
    .partial_sum_in11(partial_sum_in11), .partial_sum_in12(partial_sum_in12),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle, scheduled by the model.
  logic [DW-1:0] e_a11[N], e_a21[N], e_w0[N], e_w1[N], e_p11[N], e_p12[N];
  logic          e_we[N], e_wr[N], e_ar[N], e_busy[N], e_done[N];
  // Observed outputs per cycle, for the literal checks.
  logic [DW-1:0] h_a11[N], h_a21[N], h_w0[N], h_w1[N], h_p11[N], h_p12[N];
  logic          h_we[N], h_wr[N], h_ar[N], h_busy[N], h_done[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      e_a11[i] = '0; e_a21[i] = '0; e_w0[i] = '0; e_w1[i] = '0;
      e_p11[i] = '0; e_p12[i] = '0; e_we[i] = 1'b0; e_wr[i] = 1'b0;
      e_ar[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 streaming, 3 draining.
  int            m_mode  = 0;
  int            done_at = -1;
  logic [DW-1:0] mw0 = '0, mw1 = '0, mb0 = '0, mb1 = '0;

  always @(posedge clk) begin
    int   c;
    logic wacc, aacc;
    c = cyc;
    if (c < N - 4) begin
      if (rst) begin
        m_mode = 0; done_at = -1;
        mw0 = '0; mw1 = '0; mb0 = '0; mb1 = '0;
        e_a11[c+1] = '0; e_a21[c+1] = '0; e_a21[c+2] = '0;
        e_p11[c+1] = '0; e_p11[c+2] = '0;
        e_p12[c+1] = '0; e_p12[c+2] = '0; e_p12[c+3] = '0;
        e_we[c+1] = 1'b0; e_w0[c+1] = '0; e_w1[c+1] = '0;
        e_wr[c+1] = 1'b0; e_ar[c+1] = 1'b0; e_busy[c+1] = 1'b0; e_done[c+1] = 1'b0;
      end else begin
        wacc = w_valid && e_wr[c];
        aacc = a_valid && e_ar[c];
        if (wacc) begin
          mw0 = w_data0; mw1 = w_data1;
`ifdef SA_FEEDER_BIAS_EN
          if (m_mode == 1) begin mb0 = b_data0; mb1 = b_data1; end
`endif
        end
        e_we[c+1]  = wacc;
        e_w0[c+1]  = mw0;
        e_w1[c+1]  = mw1;
        e_a11[c+1] = aacc ? a_data0 : '0;
        e_a21[c+2] = aacc ? a_data1 : '0;
        e_p11[c+2] = aacc ? mb0 : '0;
        e_p12[c+3] = aacc ? mb1 : '0;
        case (m_mode)
          0: if (wacc) m_mode = 1;
          1: if (wacc) m_mode = 2;
          2: if (aacc && a_last) begin m_mode = 3; done_at = c + DRAIN_CYC + 1; end
          default: if (c + 1 == done_at) m_mode = 0;
        endcase
        e_done[c+1] = (c + 1 == done_at);
        e_wr[c+1]   = (m_mode <= 1);
        e_ar[c+1]   = (m_mode == 2);
        e_busy[c+1] = (m_mode != 0);
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc > 0 && cyc < N - 4) begin
      h_a11[cyc] = activation_in11; h_a21[cyc] = activation_in21;
      h_w0[cyc] = weight_in11; h_w1[cyc] = weight_in12; h_we[cyc] = weight_en;
      h_p11[cyc] = partial_sum_in11; h_p12[cyc] = partial_sum_in12;
      h_wr[cyc] = w_ready; h_ar[cyc] = a_ready; h_busy[cyc] = busy; h_done[cyc] = done;
      check("act11", activation_in11, e_a11[cyc]);
      check("act21", activation_in21, e_a21[cyc]);
      check("w11", weight_in11, e_w0[cyc]);
      check("w12", weight_in12, e_w1[cyc]);
      check("w_en", weight_en, e_we[cyc]);
      check("psum11", partial_sum_in11, e_p11[cyc]);
      check("psum12", partial_sum_in12, e_p12[cyc]);
      check("w_ready", w_ready, e_wr[cyc]);
      check("a_ready", a_ready, e_ar[cyc]);
      check("busy", busy, e_busy[cyc]);
      check("done", done, e_done[cyc]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_w(input logic [DW-1:0] d0, d1, bb0, bb1, output int tacc);
    w_valid = 1'b1; w_data0 = d0; w_data1 = d1; b_data0 = bb0; b_data1 = bb1;
    tacc = -1;
    for (int i = 0; i < 20 && tacc < 0; i++) begin
      @(negedge clk); if (w_ready) tacc = cyc;
      tick();
    end
    w_valid = 1'b0;
    if (tacc < 0) begin checks++; errors++; $display("FAIL send_w: no accept within 20 cycles"); tacc = 0; end
  endtask

  task automatic send_a(input logic [DW-1:0] d0, d1, input logic last, output int tacc);
    a_valid = 1'b1; a_data0 = d0; a_data1 = d1; a_last = last;
    tacc = -1;
    for (int i = 0; i < 20 && tacc < 0; i++) begin
      @(negedge clk); if (a_ready) tacc = cyc;
      tick();
    end
    a_valid = 1'b0; a_last = 1'b0;
    if (tacc < 0) begin checks++; errors++; $display("FAIL send_a: no accept within 20 cycles"); tacc = 0; end
  endtask

  task automatic load_weights(output int t0, output int t1);
    send_w(16'd1, 16'd2, 16'd0, 16'd0, t0);
    send_w(16'd3, 16'd4, 16'd10, 16'hFFFD, t1);
  endtask

  int tw0, tw1, ta, ta0, ta1, tb0, tb1, td, ndone;

  initial begin
    rst = 1'b1; w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    w_data0 = '0; w_data1 = '0; b_data0 = '0; b_data1 = '0; a_data0 = '0; a_data1 = '0;
    repeat (2) tick();
    rst = 1'b0;
    idle(1);
    check("rst_busy", h_busy[2], 1'b0);
    check("rst_w_ready", h_wr[2], 1'b0);
    check("rst_act11", h_a11[2], 16'd0);

    // Abort mid-stream with reset.
    load_weights(tw0, tw1);
    send_a(16'd31, 16'd32, 1'b0, ta);
    rst = 1'b1; tick(); rst = 1'b0;
    idle(10);
    check("mid_act11_before", h_a11[ta+1], 16'd31);
    check("mid_act11_after", h_a11[ta+2], 16'd0);
    check("mid_act21_after", h_a21[ta+2], 16'd0);
    check("mid_busy_after", h_busy[ta+2], 1'b0);
    ndone = 0;
    for (int i = ta + 1; i < ta + 10; i++) ndone += int'(h_done[i]);
    check("mid_no_done", 32'(ndone), 32'd0);

    // Weights then back-to-back vectors; stray valids during drain.
    load_weights(tw0, tw1);
    send_a(16'd5, 16'd6, 1'b0, ta0);
    send_a(16'd7, 16'd8, 1'b1, ta1);
    a_valid = 1'b1; a_last = 1'b1; w_valid = 1'b1;
    repeat (3) tick();
    idle(5);
    check("w_en_beat0", h_we[tw0+1], 1'b1);
    check("w11_beat0", h_w0[tw0+1], 16'd1);
    check("w12_beat0", h_w1[tw0+1], 16'd2);
    check("w11_beat1", h_w0[tw1+1], 16'd3);
    check("w12_beat1", h_w1[tw1+1], 16'd4);
    check("w_en_after", h_we[tw1+2], 1'b0);
    check("stream_entered", h_ar[tw1+1], 1'b1);
    check("back_to_back", 32'(ta1 - ta0), 32'd1);
    check("v0_act11", h_a11[ta0+1], 16'd5);
    check("v1_act11", h_a11[ta1+1], 16'd7);
    check("v0_act21", h_a21[ta0+2], 16'd6);
    check("v1_act21", h_a21[ta1+2], 16'd8);
    check("drain_a_ready", h_ar[ta1+2], 1'b0);
    check("drain_w_ready", h_wr[ta1+3], 1'b0);
    check("drain_busy", h_busy[ta1+4], 1'b1);
    check("done_early", h_done[ta1+4], 1'b0);
    check("done_pulse", h_done[ta1+5], 1'b1);
    check("done_one_cycle", h_done[ta1+6], 1'b0);
    check("idle_after_done", h_busy[ta1+5], 1'b0);
`ifdef SA_FEEDER_BIAS_EN
    check("bias11", h_p11[ta0+2], 16'd10);
    check("bias12", h_p12[ta0+3], 16'hFFFD);
`else
    check("psum11_zero", h_p11[ta0+2], 16'd0);
`endif

    // Bubble between two vectors.
    load_weights(tw0, tw1);
    send_a(16'd11, 16'd12, 1'b0, tb0);
    idle(1);
    send_a(16'd13, 16'd14, 1'b1, tb1);
    idle(8);
    check("bub_act11_a", h_a11[tb0+1], 16'd11);
    check("bub_act11_gap", h_a11[tb0+2], 16'd0);
    check("bub_act11_b", h_a11[tb0+3], 16'd13);
    check("bub_act21_a", h_a21[tb0+2], 16'd12);
    check("bub_act21_gap", h_a21[tb0+3], 16'd0);
    check("bub_act21_b", h_a21[tb0+4], 16'd14);
`ifdef SA_FEEDER_BIAS_EN
    check("bub_bias11_gap", h_p11[tb0+3], 16'd0);
    check("bub_bias12_gap", h_p12[tb0+4], 16'd0);
    check("bub_bias12_b", h_p12[tb0+5], 16'hFFFD);
`endif

    // a_last on the very first vector.
    load_weights(tw0, tw1);
    send_a(16'd21, 16'd22, 1'b1, td);
    idle(8);
    check("single_a_ready", h_ar[td+1], 1'b0);
    check("single_act21", h_a21[td+2], 16'd22);
    check("single_done", h_done[td+5], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
